oled_init_sequencer: RTL and testbench

OLED_INIT_SEQUENCER -- requirements
Module: oled_init_sequencer

---
 rtl/oled_init_sequencer.sv | 132 +++++++++++++
 tb/tb_oled_init_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/oled_init_sequencer.sv
// Streams the SSD1306 power-up command list to an I2C transaction block, then
// periodically toggles display inversion; a missing op_done parks the block in ERROR.
module oled_init_sequencer #(
   parameter logic [7:0] I2C_ADDR       = 8'h78,
   parameter int         GAP_CYCLES     = 16,
   parameter int         TIMEOUT_CYCLES = 2_000_000,
   parameter int         BLINK_CYCLES   = 27_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       op_done,
   output logic [7:0] address,
   output logic [7:0] control,
   output logic [7:0] data,
   output logic       op_start,
   output logic       busy,
   output logic       init_done,
   output logic       error,
   output logic [4:0] cmd_index
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int BW = $clog2(BLINK_CYCLES + 1);
   localparam logic [4:0] LAST_CMD = 5'd24;

   typedef enum logic [2:0] {IDLE, LOAD, REQ, GAP, BLINK_WAIT, ERROR} state_t;
   state_t state, state_nxt;

   logic [TW-1:0] tmo_cnt;
   logic [GW-1:0] gap_cnt;
   logic [BW-1:0] blink_cnt;
   logic          sync1, sync2, sync3, done_evt;
   logic          invert;
   logic          tmo_last, gap_last, blink_last, advance;

   function automatic logic [7:0] rom_byte(input logic [4:0] idx);
      case (idx)
         5'd0:  return 8'hAE;  5'd1:  return 8'hD5;  5'd2:  return 8'h80;
         5'd3:  return 8'hA8;  5'd4:  return 8'h3F;  5'd5:  return 8'hD3;
         5'd6:  return 8'h00;  5'd7:  return 8'h40;  5'd8:  return 8'h8D;
         5'd9:  return 8'h14;  5'd10: return 8'h20;  5'd11: return 8'h00;
         5'd12: return 8'hA1;  5'd13: return 8'hC8;  5'd14: return 8'hDA;
         5'd15: return 8'h12;  5'd16: return 8'h81;  5'd17: return 8'hCF;
         5'd18: return 8'hD9;  5'd19: return 8'hF1;  5'd20: return 8'hDB;
         5'd21: return 8'h40;  5'd22: return 8'hA4;  5'd23: return 8'hA6;
         default: return 8'hAF;
      endcase
   endfunction

   assign address    = I2C_ADDR;
   assign control    = 8'h00;
   assign done_evt   = sync2 & ~sync3;
   assign tmo_last   = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign gap_last   = (gap_cnt == GW'(GAP_CYCLES - 1));
   assign blink_last = (blink_cnt == BW'(BLINK_CYCLES - 1));
   assign advance    = (state == REQ) && enable && done_evt;

   // op_done comes from another clock domain; only its synchronized rising edge counts
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= op_done;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state != ERROR && !enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:       state_nxt = init_done ? BLINK_WAIT : LOAD;
            LOAD:       state_nxt = REQ;
            REQ:        if (done_evt) state_nxt = GAP;
                        else if (tmo_last) state_nxt = ERROR;
            GAP:        if (gap_last) state_nxt = init_done ? BLINK_WAIT : LOAD;
            BLINK_WAIT: if (blink_last) state_nxt = LOAD;
            ERROR:      if (!enable) state_nxt = IDLE;
            default:    state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      op_start = 1'b0;
      busy     = 1'b0;
      case (state)
         REQ:         begin op_start = 1'b1; busy = 1'b1; end
         IDLE, ERROR: ;
         default:     busy = 1'b1;
      endcase
   end

   // Counters only run inside their own state, so none can wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt   <= '0;
         gap_cnt   <= '0;
         blink_cnt <= '0;
         data      <= 8'h00;
         cmd_index <= '0;
         init_done <= 1'b0;
         error     <= 1'b0;
         invert    <= 1'b0;
      end else begin
         tmo_cnt   <= (state == REQ)        ? tmo_cnt + TW'(1)   : '0;
         gap_cnt   <= (state == GAP)        ? gap_cnt + GW'(1)   : '0;
         blink_cnt <= (state == BLINK_WAIT) ? blink_cnt + BW'(1) : '0;
         if (state == LOAD)
            data <= init_done ? (invert ? 8'hA7 : 8'hA6) : rom_byte(cmd_index);
         if (advance && !init_done) begin
            if (cmd_index == LAST_CMD) init_done <= 1'b1;
            else                       cmd_index <= cmd_index + 5'd1;
         end
         if (state == REQ && enable && !done_evt && tmo_last)
            error <= 1'b1;
         if (state == BLINK_WAIT && enable && blink_last)
            invert <= ~invert;
      end
   end
endmodule

// File: tb/tb_oled_init_sequencer.sv
// Directed bench: init stream, abort/resume, blink, async reset, timeout/retry, held op_done.
module tb_oled_init_sequencer;
   logic       clk, rst, enable, op_done;
   logic [7:0] address, control, data;
   logic       op_start, busy, init_done, error;
   logic [4:0] cmd_index;

   oled_init_sequencer #(
      .I2C_ADDR(8'h78), .GAP_CYCLES(2), .TIMEOUT_CYCLES(50), .BLINK_CYCLES(20)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .op_done(op_done),
      .address(address), .control(control), .data(data), .op_start(op_start),
      .busy(busy), .init_done(init_done), .error(error), .cmd_index(cmd_index)
   );

   logic [7:0] rom_exp [0:24] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                  8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                                  8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                                  8'hAF};

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Transaction monitor plus I2C responder stand-in
   logic [7:0] txq [$];
   int         lowq [$];
   int         low_cnt = 0, high_cnt = 0, last_high = 0, stab_err = 0, resp_cnt = 0;
   logic [7:0] held = 8'h00;
   bit         st_prev = 0, pulse = 0, resp_en = 1, force_done = 0, silent5 = 0;

   initial begin
      op_done = 1'b0;
      forever begin
         @(negedge clk);
         pulse = 1'b0;
         if (rst) begin
            resp_cnt = 0;
         end else if (op_start && !st_prev) begin
            txq.push_back(data);
            lowq.push_back(low_cnt);
            held     = data;
            high_cnt = 1;
            low_cnt  = 0;
            resp_cnt = (silent5 && cmd_index == 5'd5) ? 0 : 11;
         end else if (op_start) begin
            high_cnt++;
            if (data != held) stab_err++;
         end else begin
            if (st_prev) last_high = high_cnt;
            low_cnt++;
         end
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0 && resp_en) pulse = 1'b1;
         end
         op_done = pulse | force_done;
         st_prev = op_start;
      end
   end

   initial begin
      int min_low;
      int k;
      rst    = 1'b1;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_op_start", op_start, 0);
      check("rst_data", data, 8'h00);
      check("rst_cmd_index", cmd_index, 0);
      check("rst_busy", busy, 0);
      check("rst_init_done", init_done, 0);
      check("rst_error", error, 0);
      check("address", address, 8'h78);
      check("control", control, 8'h00);
      rst = 1'b0;
      @(negedge clk);

      // Abort during entry 3, idle long enough for the stale op_done to land, then resume
      enable = 1'b1;
      for (int i = 0; i < 300 && !(op_start && cmd_index == 5'd3); i++) @(negedge clk);
      check("wait_entry3", op_start && cmd_index == 5'd3, 1);
      enable = 1'b0;
      @(negedge clk);
      check("abort_op_start", op_start, 0);
      check("abort_busy", busy, 0);
      check("abort_cmd_index", cmd_index, 3);
      repeat (20) @(negedge clk);
      enable = 1'b1;

      for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk);
      check("wait_init", init_done, 1);
      check("init_cmd_index", cmd_index, 24);
      check("init_error", error, 0);
      check("init_tx_count", txq.size(), 26);
      for (int i = 0; i < 26; i++)
         check($sformatf("init_seq[%0d]", i), txq[i], rom_exp[(i < 4) ? i : i - 1]);
      min_low = 1000;
      for (int i = 1; i < lowq.size(); i++)
         if (lowq[i] < min_low) min_low = lowq[i];
      check("min_low_gap", min_low, 3);
      check("data_stable", stab_err, 0);

      // Blink phase: 2 gap + 20 wait + 1 load cycles low before each inversion command
      txq.delete();
      lowq.delete();
      for (int i = 0; i < 300 && txq.size() < 3; i++) @(negedge clk);
      check("blink_tx_count", txq.size(), 3);
      check("blink0", txq[0], 8'hA7);
      check("blink1", txq[1], 8'hA6);
      check("blink2", txq[2], 8'hA7);
      check("blink0_low", lowq[0], 23);
      check("blink1_low", lowq[1], 23);
      check("blink_init_done", init_done, 1);

      // Asynchronous reset in mid-transaction, between clock edges
      for (int i = 0; i < 100 && !op_start; i++) @(negedge clk);
      check("wait_blink_req", op_start, 1);
      #3 rst = 1'b1;
      #1;
      check("arst_op_start", op_start, 0);
      check("arst_init_done", init_done, 0);
      check("arst_data", data, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 400 && !(op_start && cmd_index == 5'd10); i++) @(negedge clk);
      check("wait_entry10", op_start && cmd_index == 5'd10, 1);
      #3 rst = 1'b1;
      #1;
      check("arst10_op_start", op_start, 0);
      check("arst10_cmd_index", cmd_index, 0);
      check("arst10_busy", busy, 0);
      check("arst10_data", data, 8'h00);
      @(negedge clk);
      rst     = 1'b0;
      silent5 = 1'b1;
      txq.delete();
      for (int i = 0; i < 20 && txq.size() < 1; i++) @(negedge clk);
      check("restart_first", txq[0], 8'hAE);

      // Responder silent on entry 5
      for (int i = 0; i < 600 && !error; i++) @(negedge clk);
      check("wait_error", error, 1);
      @(negedge clk);
      check("tmo_high_cycles", last_high, 50);
      check("err_op_start", op_start, 0);
      check("err_busy", busy, 0);
      check("err_cmd_index", cmd_index, 5);
      silent5 = 1'b0;
      enable  = 1'b0;
      repeat (3) @(negedge clk);
      check("err_idle_busy", busy, 0);
      check("err_sticky", error, 1);
      txq.delete();
      enable = 1'b1;
      for (int i = 0; i < 20 && txq.size() < 1; i++) @(negedge clk);
      check("retry_data", txq[0], 8'hD3);
      for (int i = 0; i < 100 && cmd_index != 5'd6; i++) @(negedge clk);
      check("retry_advance", cmd_index, 6);
      check("retry_error_kept", error, 1);

      // op_done held high across two transactions: one advance per rising edge
      resp_en = 1'b0;
      for (int i = 0; i < 50 && !op_start; i++) @(negedge clk);
      check("wait_hold_req", op_start, 1);
      k = int'(cmd_index);
      force_done = 1'b1;
      for (int i = 0; i < 50 && !(op_start && cmd_index == 5'(k + 1)); i++) @(negedge clk);
      check("hold_first_adv", cmd_index, k + 1);
      repeat (5) @(negedge clk);
      check("hold_no_adv", cmd_index, k + 1);
      check("hold_still_req", op_start, 1);
      force_done = 1'b0;
      repeat (4) @(negedge clk);
      force_done = 1'b1;
      for (int i = 0; i < 10 && cmd_index != 5'(k + 2); i++) @(negedge clk);
      check("hold_second_adv", cmd_index, k + 2);
      force_done = 1'b0;
      resp_en    = 1'b1;
      for (int i = 0; i < 100 && cmd_index != 5'(k + 3); i++) @(negedge clk);
      check("hold_resume", cmd_index, k + 3);
      check("final_data_stable", stab_err, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
